// File: rtl/gpio_ctrl_if.sv
// Bus interface between the load/store unit (master) and gpio_ctrl (slave).
// One request per cycle; the slave returns a single-cycle ack on the next cycle.
interface gpio_ctrl_if;
   logic        req;
   logic        we;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;

   modport master (output req, output we, output addr, output wdata,
                   input  rdata, input ack);
   modport slave  (input  req, input  we, input  addr, input  wdata,
                   output rdata, output ack);
endinterface

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: GPO output register, synchronized and
// debounced GPI inputs, sticky rising-edge flags.
// Optional interrupt logic (irq output, MASK register) is enabled by GPIO_IRQ_EN.
module gpio_ctrl #(
   parameter int unsigned DEB_CYCLES = 4,
   parameter logic [25:0] RESET_GPO  = 26'h0
) (
   input  logic        CLOCK_50,
   input  logic        rst,
   gpio_ctrl_if.slave  bus,
   input  logic [9:0]  GPI,
   output logic [25:0] GPO,
   output logic        irq
);

   localparam int CNT_W = $clog2(DEB_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      REG_GPO  = 2'd0,
      REG_GPI  = 2'd1,
      REG_EDGE = 2'd2,
      REG_MASK = 2'd3
   } reg_sel_e;

   reg_sel_e         sel;
   logic             wr;
   logic             rd;
   logic [9:0]       s1;
   logic [9:0]       s2;
   logic [9:0]       stable;
   logic [9:0]       stable_next;
   logic [CNT_W-1:0] cnt [10];
   logic [9:0]       edge_q;
   logic [9:0]       w1c;
   logic [9:0]       mask;
   logic [31:0]      rdata_next;
   logic             unused_bits;

   assign sel = reg_sel_e'(bus.addr[3:2]);
   assign wr  = bus.req & bus.we;
   assign rd  = bus.req & ~bus.we;
   assign w1c = (wr && sel == REG_EDGE) ? bus.wdata[9:0] : 10'h0;

   // Byte-lane bits and the upper data bits never select or carry anything.
   assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:26]};

   // Two-flop synchronizer for the asynchronous board inputs.
   always_ff @(posedge CLOCK_50 or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= GPI;
         s2 <= s2 == s1 ? s2 : s1;
      end
   end

   // Debounced value adopts s2 once it has differed for DEB_CYCLES edges.
   always_comb begin
      // NOTE: default assignment first so no path leaves stable_next unassigned
      // (which would infer a latch).
      stable_next = stable;
      for (int i = 0; i < 10; i++) begin
         if (s2[i] != stable[i] && cnt[i] == CNT_MAX) stable_next[i] = s2[i];
      end
   end

   // Debounce counters and debounced value.
   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         stable <= '0;
         // NOTE: the counter array is small and its reset value matters (a
         // partial count must be discarded), so it is reset like any flop.
         for (int i = 0; i < 10; i++) cnt[i] <= '0;
      end else begin
         stable <= stable_next;
         for (int i = 0; i < 10; i++) begin
            if (s2[i] == stable[i] || cnt[i] == CNT_MAX) cnt[i] <= '0;
            else                                         cnt[i] <= cnt[i] + CNT_W'(1);
         end
      end
   end

   // Sticky rising-edge flags; a new rise beats a simultaneous W1C.
   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) edge_q <= '0;
      else     edge_q <= (edge_q & ~w1c) | (stable_next & ~stable);
   end

   // GPO output register.
   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst)                        GPO <= RESET_GPO;
      else if (wr && sel == REG_GPO)  GPO <= bus.wdata[25:0];
   end

`ifdef GPIO_IRQ_EN
   // Interrupt mask register.
   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst)                        mask <= '0;
      else if (wr && sel == REG_MASK) mask <= bus.wdata[9:0];
   end

   // Registered interrupt: any flagged edge that is unmasked.
   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) irq <= 1'b0;
      else     irq <= |(edge_q & mask);
   end
`else
   assign mask = '0;
   assign irq  = 1'b0;
`endif

   // Read mux: zero outside reads so rdata is 0 whenever ack is low.
   always_comb begin
      rdata_next = '0;
      if (rd) begin
         unique case (sel)
            REG_GPO:  rdata_next = {6'h0, GPO};
            REG_GPI:  rdata_next = {22'h0, stable};
            REG_EDGE: rdata_next = {22'h0, edge_q};
            REG_MASK: rdata_next = {22'h0, mask};
         endcase
      end
   end

   // Fixed one-cycle response for every accepted request.
   always_ff @(posedge CLOCK_50 or posedge rst) begin
      if (rst) begin
         bus.ack   <= 1'b0;
         bus.rdata <= '0;
      end else begin
         bus.ack   <= bus.req;
         bus.rdata <= rdata_next;
      end
   end

endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
- Memory-mapped GPIO controller between the RV32I core's load/store unit and the board pins.
- Drives the 26-bit GPO bus from a write-only-by-bus output register.
- Samples the 10-bit GPI bus through a 2-FF synchronizer and a per-bit debouncer, then latches sticky rising edges.
- Services one bus request per cycle with a fixed 1-cycle ack.

Parameters:
- DEB_CYCLES, 4, consecutive cycles a synchronized input must differ from its debounced value before that value updates; legal range 1..65535.
- RESET_GPO, 26'h0, GPO register value at reset.

Ports:
- CLOCK_50  input  1  system clock; all state on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  bus request, one-cycle pulse per access.
- we  input  1  1 = write, 0 = read; qualified by req.
- addr  input  4  byte address; addr[3:2] selects the register, addr[1:0] ignored.
- wdata  input  32  write data; full-word writes only.
- rdata  output  32  read data; valid only while ack = 1, otherwise 0.
- ack  output  1  one-cycle completion pulse.
- GPI  input  10  asynchronous board inputs.
- GPO  output  26  board outputs, driven directly from the GPO register.
- irq  output  1  interrupt request (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): GPO = RESET_GPO, rdata = 0, ack = 0, irq = 0. Sync flops, debounced value, debounce counters, EDGE and MASK all clear to 0.
- Register map (addr[3:2]); unused bits read 0, writes to them are ignored:
  - 0: GPO, R/W, bits [25:0].
  - 1: GPI, RO, debounced value, bits [9:0]; writes are ignored.
  - 2: EDGE, R/W1C, sticky rising-edge flags, bits [9:0].
  - 3: MASK, R/W, bits [9:0].
- Bus timing:
  - A request is accepted on any cycle with req = 1.
  - ack = 1 on the following cycle, for exactly one cycle.
  - A write takes effect on the acceptance edge; a read captures the register value at the acceptance edge into rdata.
  - Back-to-back requests on consecutive cycles are legal; each receives its own ack. There is no stall and no busy state.
- Synchronizer: s1 <= GPI, s2 <= s1.
- Per-bit debouncer (counter cnt, width = clog2(DEB_CYCLES)+1):
  - If s2 == stable: cnt <= 0.
  - Else if cnt == DEB_CYCLES-1: stable <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - A GPI pin change stable since edge k is visible in the GPI register at edge k+2+DEB_CYCLES.
  - A pulse shorter than DEB_CYCLES cycles (measured at s2) never reaches stable.
- EDGE:
  - Bit i sets on the cycle stable[i] goes 0->1.
  - Writing 1 clears bit i; writing 0 has no effect.
  - A W1C and a new rising edge on the same bit in the same cycle: set wins, bit stays 1.
  - Falling edges are not recorded.
- Reading EDGE does not clear it.
- A bus write to GPO and reset asserting in the same cycle: reset wins.
- Reset asserted mid-debounce discards the partial count; there is no pending ack after reset.

Optional Feature:
- Macro: GPIO_IRQ_EN.
- Defined: irq is a registered version of |(EDGE & MASK), asserting 1 cycle after the contributing condition and deasserting 1 cycle after it clears (W1C or mask write).
- Undefined: irq is tied to 0, MASK reads 0 and writes to it are ignored. The rest of the register map is unchanged.

Test Plan:
- Reset with RESET_GPO = 26'h155: GPO = 26'h155, ack = 0, irq = 0. Reads of GPI, EDGE and MASK return 0.
- Write 32'hFFFF_FFFF to addr 0x0, then read 0x0: ack 1 cycle after each req. GPO = 26'h3FF_FFFF; rdata = 32'h03FF_FFFF.
- DEB_CYCLES = 4: GPI[3] rises and holds. A read of addr 0x4 shows bit 3 = 1 at edge k+6, not before. A 3-cycle high glitch on GPI[5] never appears in GPI or EDGE.
- After GPI[3] debounces high, EDGE reads 32'h8. Write 32'h8 to 0x8 in the same cycle as a new debounced rise on bit 3: EDGE stays 32'h8. A later W1C with no new edge gives 0.
- With GPIO_IRQ_EN defined: MASK = 32'h8 and EDGE[3] set gives irq = 1 one cycle later. W1C of EDGE[3] drops irq one cycle after the clear. With the macro undefined, irq stays 0 and MASK reads 0.
- Back-to-back write 0x0 / read 0x4 / read 0x8 on 3 consecutive cycles gives 3 consecutive ack pulses with correct rdata. Asserting rst mid-sequence clears ack immediately and restores all reset values.
